// File: rtl/psram_pkg.sv
// Shared types and timing helpers for the asynchronous PSRAM controller.
package psram_pkg;

  typedef enum logic [2:0] {INIT, IDLE, RD, WR, WR_HOLD, RECOVER, ACK} state_t;

  localparam int T_ACC_NS  = 70;
  localparam int T_INIT_NS = 150000;

  function automatic int ceil_div(input int n, input int d);
    int q;
    q = (n + d - 1) / d;
    return (q < 1) ? 1 : q;
  endfunction

endpackage

// File: rtl/psram_timer.sv
// Loadable down-counter; reports zero once the loaded wait has elapsed.
module psram_timer #(
  parameter int           W       = 13,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= RST_VAL;
    else if (load)        cnt <= val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/psram_ctrl.sv
// Wishbone-classic slave driving an async 16-bit PSRAM; 32-bit requests
// become two back-to-back half-word device cycles.
module psram_ctrl
  import psram_pkg::*;
#(
  parameter int CLK_PERIOD_NS = 20
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [21:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  output logic        ack_o,
  output logic [31:0] data_o,
  output logic        psram_cen,
  output logic        psram_wen,
  output logic        psram_oen,
  output logic        psram_lbn,
  output logic        psram_ubn,
  output logic [21:0] psram_a,
  inout  logic [15:0] psram_d
);

  localparam int ACC_CYC  = ceil_div(T_ACC_NS, CLK_PERIOD_NS);
  localparam int INIT_CYC = ceil_div(T_INIT_NS, CLK_PERIOD_NS);
  localparam int TW       = $clog2(INIT_CYC + 1);
  localparam logic [TW-1:0] ACC_LD  = TW'(ACC_CYC - 1);
  localparam logic [TW-1:0] INIT_LD = TW'(INIT_CYC - 1);

  state_t      state, state_n;
  logic [21:0] addr_q, addr_n;
  logic [31:0] data_q, data_n, rdata_n;
  logic [3:0]  sel_q, sel_n;
  logic        we_q, we_n, half_q, half_n, abort_q, abort_n;
  logic        req, tmr_load, tmr_zero, act, ack_n;
  logic [15:0] dout;
  logic        doe;

  assign req     = cyc_i & stb_i;
  assign psram_d = doe ? dout : 16'hzzzz;

  // Reset preloads the power-up wait so INIT needs no extra load cycle.
  psram_timer #(.W(TW), .RST_VAL(INIT_LD)) u_timer (
    .clk   (clk_i),
    .rst_n (rst_i),
    .load  (tmr_load),
    .val   (ACC_LD),
    .zero  (tmr_zero)
  );

  always_comb begin
    state_n  = state;
    tmr_load = 1'b0;
    addr_n   = addr_q;
    data_n   = data_q;
    sel_n    = sel_q;
    we_n     = we_q;
    half_n   = half_q;
    abort_n  = abort_q | ~req;
    ack_n    = 1'b0;
    rdata_n  = data_o;
    case (state)
      INIT: if (tmr_zero) state_n = IDLE;
      IDLE: begin
        abort_n = 1'b0;
        if (req) begin
          addr_n   = addr_i;
          data_n   = data_i;
          sel_n    = sel_i;
          we_n     = we_i;
          half_n   = 1'b0;
          tmr_load = 1'b1;
          state_n  = we_i ? WR : RD;
          if (!we_i) rdata_n = '0;
        end
      end
      RD: if (tmr_zero) begin
        if (half_q) rdata_n[31:16] = psram_d;
        else        rdata_n[15:0]  = psram_d;
        state_n = RECOVER;
      end
      WR:      if (tmr_zero) state_n = WR_HOLD;
      WR_HOLD: state_n = RECOVER;
      RECOVER: begin
        // A dropped request only takes effect between device halves.
        if (abort_n) state_n = IDLE;
        else if (!half_q && sel_q[3:2] != 2'b00) begin
          half_n   = 1'b1;
          tmr_load = 1'b1;
          state_n  = we_q ? WR : RD;
        end else state_n = ACK;
      end
      ACK: if (req) ack_n = 1'b1;
           else     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    act = state_n inside {RD, WR, WR_HOLD};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= INIT;
      addr_q    <= '0;
      data_q    <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      half_q    <= 1'b0;
      abort_q   <= 1'b0;
      ack_o     <= 1'b0;
      data_o    <= '0;
      psram_cen <= 1'b1;
      psram_wen <= 1'b1;
      psram_oen <= 1'b1;
      psram_lbn <= 1'b1;
      psram_ubn <= 1'b1;
      psram_a   <= '0;
      dout      <= '0;
      doe       <= 1'b0;
    end else begin
      state     <= state_n;
      addr_q    <= addr_n;
      data_q    <= data_n;
      sel_q     <= sel_n;
      we_q      <= we_n;
      half_q    <= half_n;
      abort_q   <= abort_n;
      ack_o     <= ack_n;
      data_o    <= rdata_n;
      // Pins are decoded from the state being entered, so they track it exactly.
      psram_cen <= ~act;
      psram_wen <= ~(state_n == WR);
      psram_oen <= ~(state_n == RD);
      psram_lbn <= ~(act & (half_n ? sel_n[2] : sel_n[0]));
      psram_ubn <= ~(act & (half_n ? sel_n[3] : sel_n[1]));
      psram_a   <= addr_n + 22'(half_n);
      dout      <= half_n ? data_n[31:16] : data_n[15:0];
      doe       <= state_n inside {WR, WR_HOLD};
    end
  end

endmodule

// File: tb/tb_psram_ctrl.sv
// Directed bench for psram_ctrl with a behavioural async PSRAM model.
module tb_psram_ctrl;

  localparam int CLK_NS   = 20;
  localparam int INIT_CYC = 7500;
  localparam int WE_W     = 4 * CLK_NS;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [21:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic        ack, cen, wen, oen, lbn, ubn;
  logic [31:0] data_o;
  logic [21:0] pa;
  wire  [15:0] pd;

  int checks = 0, errors = 0;

  always #(CLK_NS/2) clk = ~clk;

  psram_ctrl #(.CLK_PERIOD_NS(CLK_NS)) dut (
    .clk_i(clk), .rst_i(rst_n), .addr_i(addr), .data_i(wdata), .stb_i(stb),
    .cyc_i(cyc), .sel_i(sel), .we_i(we), .ack_o(ack), .data_o(data_o),
    .psram_cen(cen), .psram_wen(wen), .psram_oen(oen), .psram_lbn(lbn),
    .psram_ubn(ubn), .psram_a(pa), .psram_d(pd)
  );

  // PSRAM model: lane-masked writes on WE rising, reads while OE low.
  logic [15:0] mem [logic [21:0]];
  logic [15:0] rd_v = '0, wv;
  time         t_fall = 0;
  int          np = 0;
  logic [21:0] la [16];
  logic [15:0] ld [16];
  int          lw [16];
  logic        llbn [16], lubn [16];

  always @(clk) rd_v = mem.exists(pa) ? mem[pa] : 16'h0;
  assign pd = (!cen && !oen && wen) ? rd_v : 16'hzzzz;

  always @(negedge wen) t_fall = $time;
  always @(posedge wen) if (rst_n && !cen) begin
    wv = mem.exists(pa) ? mem[pa] : 16'h0;
    if (!lbn) wv[7:0]  = pd[7:0];
    if (!ubn) wv[15:8] = pd[15:8];
    mem[pa] = wv;
    la[np%16] = pa; ld[np%16] = pd; lw[np%16] = int'($time - t_fall);
    llbn[np%16] = lbn; lubn[np%16] = ubn;
    np++;
  end

  int   since = 0;
  logic early_cen = 1'b0;
  always @(posedge clk)
    if (!rst_n) since <= 0;
    else begin
      since <= since + 1;
      if (since < INIT_CYC && !cen) early_cen <= 1'b1;
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_req(input logic w, input logic [21:0] a, input logic [3:0] s,
                        input logic [31:0] d, input int maxc, input int hold,
                        output int lat, output logic [31:0] rd, output int bad);
    @(negedge clk);
    we = w; addr = a; sel = s; wdata = d; stb = 1'b1; cyc = 1'b1;
    @(posedge clk); #1;
    lat = 0; bad = 0;
    while (!ack && lat < maxc) begin @(posedge clk); #1; lat++; end
    rd = data_o;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!ack || !cen) bad++;
    end
    @(negedge clk); stb = 1'b0; cyc = 1'b0;
    @(posedge clk); #1;
    if (ack) bad++;
  endtask

  typedef struct {
    logic w; logic [21:0] a; logic [3:0] s; logic [31:0] d;
    logic [31:0] exp_d; int lat; int np; logic lbn; logic ubn; logic [21:0] exp_a;
  } vec_t;

  initial begin
    vec_t v [11];
    int lat, bad, np0, idx;
    logic [31:0] rd;
    logic saw;
    v[0]  = '{1'b1, 22'h000100, 4'b0010, 32'h0000AB00, 32'h0,        7, 1, 1'b1, 1'b0, 22'h000100};
    v[1]  = '{1'b0, 22'h000100, 4'b1111, 32'h0,        32'hDEADABEF, 11, 0, 1'b1, 1'b1, 22'h0};
    v[2]  = '{1'b0, 22'h000101, 4'b0011, 32'h0,        32'h0000DEAD, 6, 0, 1'b1, 1'b1, 22'h0};
    v[3]  = '{1'b1, 22'h3FFFFF, 4'b1111, 32'h12345678, 32'h0,        13, 2, 1'b0, 1'b0, 22'h000000};
    v[4]  = '{1'b0, 22'h000000, 4'b0011, 32'h0,        32'h00001234, 6, 0, 1'b1, 1'b1, 22'h0};
    v[5]  = '{1'b0, 22'h3FFFFF, 4'b1111, 32'h0,        32'h12345678, 11, 0, 1'b1, 1'b1, 22'h0};
    v[6]  = '{1'b1, 22'h000200, 4'b0001, 32'h000000CD, 32'h0,        7, 1, 1'b0, 1'b1, 22'h000200};
    v[7]  = '{1'b0, 22'h000200, 4'b0011, 32'h0,        32'h000000CD, 6, 0, 1'b1, 1'b1, 22'h0};
    v[8]  = '{1'b0, 22'h000100, 4'b0001, 32'h0,        32'h0000ABEF, 6, 0, 1'b1, 1'b1, 22'h0};
    v[9]  = '{1'b1, 22'h000300, 4'b0011, 32'h0000CAFE, 32'h0,        7, 1, 1'b0, 1'b0, 22'h000300};
    v[10] = '{1'b0, 22'h000300, 4'b0011, 32'h0,        32'h0000CAFE, 6, 0, 1'b1, 1'b1, 22'h0};

    #35;
    chk("rst_ctrl", 32'({cen, wen, oen, lbn, ubn}), 32'h1f);
    chk("rst_addr", 32'(pa), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_data", data_o, 32'h0);
    chk("rst_pd_z", 32'(pd === 16'hzzzz), 32'h1);

    @(negedge clk); rst_n = 1'b1;
    np0 = np;
    do_req(1'b1, 22'h000100, 4'b1111, 32'hDEADBEEF, 9000, 0, lat, rd, bad);
    chk("init_lat_min", 32'(lat >= INIT_CYC), 32'h1);
    chk("init_lat_max", 32'(lat <= INIT_CYC + 20), 32'h1);
    chk("init_no_cen", 32'(early_cen), 32'h0);
    chk("init_ack_clear", 32'(bad), 32'h0);
    chk("w1_pulses", 32'(np - np0), 32'h2);
    chk("w1_a0", 32'(la[np0%16]), 32'h100);
    chk("w1_d0", 32'(ld[np0%16]), 32'hBEEF);
    chk("w1_w0", 32'(lw[np0%16]), 32'(WE_W));
    chk("w1_a1", 32'(la[(np0+1)%16]), 32'h101);
    chk("w1_d1", 32'(ld[(np0+1)%16]), 32'hDEAD);
    chk("w1_w1", 32'(lw[(np0+1)%16]), 32'(WE_W));

    // Readback with stb held five cycles past ack.
    do_req(1'b0, 22'h000100, 4'b1111, 32'h0, 100, 5, lat, rd, bad);
    chk("hold_lat", 32'(lat), 32'd11);
    chk("hold_data", rd, 32'hDEADBEEF);
    chk("hold_ack_stays", 32'(bad), 32'h0);

    for (int i = 0; i < 11; i++) begin
      np0 = np;
      do_req(v[i].w, v[i].a, v[i].s, v[i].d, 100, 0, lat, rd, bad);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(v[i].lat));
      chk($sformatf("v%0d_pulses", i), 32'(np - np0), 32'(v[i].np));
      chk($sformatf("v%0d_ack_clear", i), 32'(bad), 32'h0);
      if (v[i].w) begin
        idx = (np + 15) % 16;
        chk($sformatf("v%0d_lanes", i), 32'({llbn[idx], lubn[idx]}), 32'({v[i].lbn, v[i].ubn}));
        chk($sformatf("v%0d_addr", i), 32'(la[idx]), 32'(v[i].exp_a));
        chk($sformatf("v%0d_width", i), 32'(lw[idx]), 32'(WE_W));
      end else
        chk($sformatf("v%0d_data", i), rd, v[i].exp_d);
    end

    // Abort a word read during its first half.
    @(negedge clk);
    we = 1'b0; addr = 22'h000100; sel = 4'b1111; stb = 1'b1; cyc = 1'b1;
    repeat (3) @(negedge clk);
    stb = 1'b0; cyc = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 15; i++) begin @(posedge clk); #1; if (ack) saw = 1'b1; end
    chk("abort_no_ack", 32'(saw), 32'h0);
    chk("abort_cen_idle", 32'(cen), 32'h1);
    do_req(1'b0, 22'h000101, 4'b0011, 32'h0, 100, 0, lat, rd, bad);
    chk("post_abort_lat", 32'(lat), 32'd6);
    chk("post_abort_data", rd, 32'h0000DEAD);

    // Asynchronous reset in the middle of a write pulse.
    @(negedge clk);
    we = 1'b1; addr = 22'h000080; sel = 4'b1111; wdata = 32'h55AA55AA; stb = 1'b1; cyc = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("mw_wen_low", 32'(wen), 32'h0);
    #4 rst_n = 1'b0;
    #1;
    chk("mw_ctrl", 32'({cen, wen, oen, lbn, ubn}), 32'h1f);
    chk("mw_pd_z", 32'(pd === 16'hzzzz), 32'h1);
    chk("mw_ack", 32'(ack), 32'h0);
    stb = 1'b0; cyc = 1'b0;
    #40;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
